sub_accumulate48: RTL and testbench
===================================

# sub_accumulate48

Signed accumulation stage that sits directly downstream of the 48-bit negation path. It accepts a stream of signed 32-bit terms, each tagged add or subtract, and sign-extends each term to 48 bits. Subtract-tagged terms are negated in two's complement. Every term is summed into a 48-bit accumulator. After `N_TERMS` terms, or an earlier `in_last`, it presents the batch result with a sticky signed-overflow flag on a valid/ready output port. This is the summation step of the uncertainty-propagation datapath.

## Interface
- `N_TERMS`, default 4: maximum terms per batch. Range 1..65535.
- `IN_W`, default 32: input term width.
- `ACC_W`, default 48: accumulator/result width. Requires `ACC_W > IN_W`.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `in_valid` in 1: term present.
- `in_ready` out 1: block can accept a term.
- `in_data` in `IN_W`: signed term, two's complement.
- `in_sub` in 1: 1 means subtract the term (accumulate `-in_data`); 0 means add it.
- `in_last` in 1: this term closes the batch early.
- `out_valid` out 1: batch result present.
- `out_ready` in 1: consumer takes the result.
- `out_data` out `ACC_W`: signed batch sum, modulo 2^`ACC_W`.
- `out_ovf` out 1: at least one signed overflow occurred during the batch.
- `out_count` out 16: number of terms in the batch.

## Operation
- Reset values: `in_ready=0` while `rst` is high; `out_valid=0`, `out_data=0`, `out_ovf=0`, `out_count=0`, accumulator=0, term counter=0, state=ACC.
- **States**
  - ACC: `in_ready=1`, `out_valid=0`.
  - HOLD: `in_ready=0`, `out_valid=1`.
- **Term conditioning (combinational)**
  - t = sign-extend(`in_data`) to `ACC_W`.
  - If `in_sub` is set, t = (~t) + 1, computed at `ACC_W` bits.
  - Input -2^31 negates to +2^31 exactly; there is no input-side overflow.
- **Accept** (ACC and `in_valid`)
  - acc ← acc + t, modulo 2^`ACC_W`.
  - cnt ← cnt + 1.
  - ovf ← ovf | (sign(acc) == sign(t) && sign(sum) != sign(acc)).
- **Batch close**
  - Trigger: the accepted term has `in_last=1`, or cnt+1 == `N_TERMS`.
  - Register `out_data`=sum, `out_ovf`=new ovf, `out_count`=cnt+1.
  - Clear acc, cnt and ovf.
  - Go to HOLD.
- **HOLD**
  - Outputs stay stable while `out_ready=0`.
  - When `out_ready=1`: go to ACC; `out_valid` falls the next cycle.
  - No input is accepted in HOLD; `in_data` is ignored.
- **Defined cases**
  - `in_last` on the first term: batch of 1, `out_count=1`.
  - `in_last` coinciding with the count limit: a single close.
  - `in_valid=0` in ACC: no state change.
- **Reset mid-batch:** a partial sum is discarded and no output is produced.

## Timing
- Throughput: one term per cycle in ACC.
- Latency: the closing term is accepted at edge k; `out_valid=1` is visible after edge k.
- Minimum batch period: batch length + 1 cycle. The HOLD handshake costs at least 1 cycle; there is no output skid buffer.
- `in_ready` depends only on state, with no combinational path from `out_ready`. There is no combinational input-to-output path.
- Critical path: `IN_W`-bit invert, `ACC_W`-bit increment, then `ACC_W`-bit add. It maps onto the DSP add primitives in two cascaded 48-bit adds, or a 32+16 split with carry.

## Structure
- Shared package holds:
  - the constants `ACC_W_DEF=48`, `IN_W_DEF=32`, `CNT_W=16`;
  - the state encoding `ST_ACC=1'b0`, `ST_HOLD=1'b1`.
- One sub-module, `term_cond48`, is combinational: sign-extend plus conditional two's-complement negate. It is reusable by other summation stages.
- The top level holds the FSM, accumulator, counter, overflow logic and output registers.

## Test plan
- **Mixed batch:** `N_TERMS=4`, terms +5, sub 3, sub -7, +0x7FFFFFFF with no `in_last`. Require `out_data`=0x000080000008, `out_count`=4, `out_ovf`=0, `out_valid` one cycle after the 4th accept.
- **Negate extreme:** single term `in_data`=0x80000000, `in_sub=1`, `in_last=1`. Require `out_data`=0x000080000000, `out_count`=1.
- **Overflow:** `ACC_W=33`, `IN_W=32`, terms +0x7FFFFFFF ×3 with `in_last` on the 3rd. Require `out_ovf=1` and `out_data`=0x17FFFFFFD mod 2^33.
- **Backpressure:** hold `out_ready=0` for 5 cycles after close. Require `out_valid` and `out_data` stable, `in_ready=0` throughout, and a new batch accepted the cycle after `out_ready=1`.
- **Early last:** `in_last` on the 2nd of `N_TERMS=4`, values 10 and sub 4. Require `out_data`=6, `out_count`=2.
- **Async reset mid-batch:** assert `rst` between clock edges after 2 accepted terms. Require all outputs 0 immediately, and a following 4-term batch of +1s gives `out_data`=4.

Source files
------------

// File: rtl/sub_accumulate48_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sub_accumulate48_pkg
// Description : Shared widths and FSM encoding for the signed accumulation stage.
// Revision    : 1.0 - initial release
// ============================================================================
package sub_accumulate48_pkg;

    localparam int ACC_W_DEF = 48;
    localparam int IN_W_DEF  = 32;
    localparam int CNT_W     = 16;

    localparam logic [0:0] ST_ACC  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

endpackage
`default_nettype wire

// File: rtl/term_cond48.sv
`default_nettype none
// ============================================================================
// Module      : term_cond48
// Description : Sign-extends a term to accumulator width and optionally negates it.
// Revision    : 1.0 - initial release
// ============================================================================
module term_cond48 #(
    parameter int IN_W  = 32,
    parameter int ACC_W = 48
) (
    input  logic [IN_W-1:0]  i_data,
    input  logic             i_sub,
    output logic [ACC_W-1:0] o_term
);

    logic [ACC_W-1:0] w_ext;

    // Negation happens after extension, so the most negative input becomes a positive value.
    assign w_ext  = {{(ACC_W-IN_W){i_data[IN_W-1]}}, i_data};
    assign o_term = i_sub ? (~w_ext + ACC_W'(1)) : w_ext;

endmodule
`default_nettype wire

// File: rtl/sub_accumulate48.sv
`default_nettype none
// ============================================================================
// Module      : sub_accumulate48
// Description : Batched signed accumulator with sticky overflow and valid/ready result.
// Revision    : 1.0 - initial release
// ============================================================================
module sub_accumulate48
    import sub_accumulate48_pkg::*;
#(
    parameter int N_TERMS = 4,
    parameter int IN_W    = IN_W_DEF,
    parameter int ACC_W   = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_sub,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count
);

    logic [0:0]       r_state_q, w_state_d;
    logic [ACC_W-1:0] r_acc_q, w_acc_d;
    logic [CNT_W-1:0] r_cnt_q, w_cnt_d;
    logic             r_ovf_q, w_ovf_d;
    logic [ACC_W-1:0] r_out_data_q, w_out_data_d;
    logic             r_out_ovf_q, w_out_ovf_d;
    logic [CNT_W-1:0] r_out_count_q, w_out_count_d;

    logic [ACC_W-1:0] w_term;
    logic [ACC_W-1:0] w_sum;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_ovf_new;
    logic             w_accept;
    logic             w_close;

    term_cond48 #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_term_cond (
        .i_data (in_data),
        .i_sub  (in_sub),
        .o_term (w_term)
    );

    assign w_sum     = r_acc_q + w_term;
    assign w_cnt_inc = r_cnt_q + CNT_W'(1);
    // Signed overflow: operands share a sign that the wrapped sum does not.
    assign w_ovf_new = r_ovf_q |
                       ((r_acc_q[ACC_W-1] == w_term[ACC_W-1]) &&
                        (w_sum[ACC_W-1] != r_acc_q[ACC_W-1]));
    assign w_accept  = (r_state_q == ST_ACC) && in_valid;
    assign w_close   = w_accept && (in_last || (w_cnt_inc == CNT_W'(N_TERMS)));

    always_comb begin
        w_state_d     = r_state_q;
        w_acc_d       = r_acc_q;
        w_cnt_d       = r_cnt_q;
        w_ovf_d       = r_ovf_q;
        w_out_data_d  = r_out_data_q;
        w_out_ovf_d   = r_out_ovf_q;
        w_out_count_d = r_out_count_q;

        if (w_close) begin
            w_out_data_d  = w_sum;
            w_out_ovf_d   = w_ovf_new;
            w_out_count_d = w_cnt_inc;
            w_acc_d       = '0;
            w_cnt_d       = '0;
            w_ovf_d       = 1'b0;
            w_state_d     = ST_HOLD;
        end else if (w_accept) begin
            w_acc_d = w_sum;
            w_cnt_d = w_cnt_inc;
            w_ovf_d = w_ovf_new;
        end else if ((r_state_q == ST_HOLD) && out_ready) begin
            w_state_d = ST_ACC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q     <= ST_ACC;
            r_acc_q       <= '0;
            r_cnt_q       <= '0;
            r_ovf_q       <= 1'b0;
            r_out_data_q  <= '0;
            r_out_ovf_q   <= 1'b0;
            r_out_count_q <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_acc_q       <= w_acc_d;
            r_cnt_q       <= w_cnt_d;
            r_ovf_q       <= w_ovf_d;
            r_out_data_q  <= w_out_data_d;
            r_out_ovf_q   <= w_out_ovf_d;
            r_out_count_q <= w_out_count_d;
        end
    end

    // Ready is a pure function of state, masked only while reset is held.
    assign in_ready  = (r_state_q == ST_ACC) && !rst;
    assign out_valid = (r_state_q == ST_HOLD);
    assign out_data  = r_out_data_q;
    assign out_ovf   = r_out_ovf_q;
    assign out_count = r_out_count_q;

endmodule
`default_nettype wire

// File: tb/tb_sub_accumulate48.sv
`default_nettype none
// ============================================================================
// Module      : tb_sub_accumulate48
// Description : Self-checking bench for sub_accumulate48 (48-bit and 33-bit builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sub_accumulate48;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_sub = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, out_ovf;
    logic [47:0] out_data;
    logic [15:0] out_count;
    logic        in_ready33, out_valid33, out_ovf33;
    logic [32:0] out_data33;
    logic [15:0] out_count33;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    sub_accumulate48 #(.N_TERMS(4), .IN_W(32), .ACC_W(48)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sub(in_sub), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ovf(out_ovf), .out_count(out_count)
    );

    sub_accumulate48 #(.N_TERMS(4), .IN_W(32), .ACC_W(33)) dut33 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready33),
        .in_data(in_data), .in_sub(in_sub), .in_last(in_last),
        .out_valid(out_valid33), .out_ready(out_ready), .out_data(out_data33),
        .out_ovf(out_ovf33), .out_count(out_count33)
    );

    typedef struct {
        logic [31:0] d;
        bit          sub;
        bit          last;
        bit          close;
        logic [47:0] exp_data;
        int          exp_cnt;
        bit          exp_ovf;
    } vec_t;

    vec_t tbl[7];

    // Reference model state: mathematical running sums kept in signed range per width.
    longint m_a48, m_a33;
    bit     m_o48, m_o33;
    int     m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void mstep(input longint v, input int w, inout longint a, inout bit o);
        longint s, hi, lo;
        s  = a + v;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -(longint'(1) <<< (w - 1));
        if (s > hi) begin o = 1'b1; s = s - (longint'(1) <<< w); end
        else if (s < lo) begin o = 1'b1; s = s + (longint'(1) <<< w); end
        a = s;
    endfunction

    task automatic put(input logic [31:0] d, input bit s, input bit l);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_data = d; in_sub = s; in_last = l;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic consume(input int hold_cycles);
        repeat (hold_cycles) @(negedge clk);
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        chk("valid_drop", 64'(out_valid), 64'd0);
        chk("ready_back", 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [47:0] hold_data;
        logic [31:0] d;
        bit s, l;
        longint v;

        tbl[0] = '{32'd5,          1'b0, 1'b0, 1'b0, 48'h0,            0, 1'b0};
        tbl[1] = '{32'd3,          1'b1, 1'b0, 1'b0, 48'h0,            0, 1'b0};
        tbl[2] = '{32'hFFFFFFF9,   1'b1, 1'b0, 1'b0, 48'h0,            0, 1'b0};
        tbl[3] = '{32'h7FFFFFFF,   1'b0, 1'b0, 1'b1, 48'h000080000008, 4, 1'b0};
        tbl[4] = '{32'h80000000,   1'b1, 1'b1, 1'b1, 48'h000080000000, 1, 1'b0};
        tbl[5] = '{32'd10,         1'b0, 1'b0, 1'b0, 48'h0,            0, 1'b0};
        tbl[6] = '{32'd4,          1'b1, 1'b1, 1'b1, 48'h000000000006, 2, 1'b0};

        // Reset state while reset is held
        #12;
        chk("rst_in_ready",   64'(in_ready),   64'd0);
        chk("rst_in_ready33", 64'(in_ready33), 64'd0);
        chk("rst_out_valid",  64'(out_valid),  64'd0);
        chk("rst_out_data",   64'(out_data),   64'd0);
        chk("rst_out_ovf",    64'(out_ovf),    64'd0);
        chk("rst_out_count",  64'(out_count),  64'd0);
        @(negedge clk); rst = 1'b0;

        // Directed table: mixed batch, negate extreme, early last
        for (int i = 0; i < 7; i++) begin
            put(tbl[i].d, tbl[i].sub, tbl[i].last);
            chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].close));
            if (tbl[i].close) begin
                chk($sformatf("tbl%0d_data", i),  64'(out_data),  64'(tbl[i].exp_data));
                chk($sformatf("tbl%0d_count", i), 64'(out_count), 64'(tbl[i].exp_cnt));
                chk($sformatf("tbl%0d_ovf", i),   64'(out_ovf),   64'(tbl[i].exp_ovf));
                chk($sformatf("tbl%0d_ready", i), 64'(in_ready),  64'd0);
                consume(0);
            end
        end

        // Overflow on the 33-bit build
        for (int i = 0; i < 3; i++) put(32'h7FFFFFFF, 1'b0, i == 2);
        chk("ovf33_valid", 64'(out_valid33), 64'd1);
        chk("ovf33_flag",  64'(out_ovf33),   64'd1);
        chk("ovf33_data",  64'(out_data33),  64'h17FFFFFFD);
        chk("ovf33_count", 64'(out_count33), 64'd3);
        chk("ovf48_flag",  64'(out_ovf),     64'd0);
        chk("ovf48_data",  64'(out_data),    64'h17FFFFFFD);
        consume(0);
        // Sticky flag must not leak into the next batch
        put(32'd1, 1'b0, 1'b1);
        chk("ovf33_clear", 64'(out_ovf33), 64'd0);
        consume(0);

        // Backpressure: outputs stable for 5 cycles, inputs ignored
        for (int i = 0; i < 4; i++) put(32'd100 + 32'(i), 1'b0, 1'b0);
        hold_data = out_data;
        chk("bp_data", 64'(hold_data), 64'd406);
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'd999; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_stable", 64'(out_data), 64'(hold_data));
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk); in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        chk("bp_release", 64'(in_ready), 64'd1);
        put(32'd7, 1'b0, 1'b1);
        chk("bp_next_valid", 64'(out_valid), 64'd1);
        chk("bp_next_data",  64'(out_data),  64'd7);
        consume(0);

        // Async reset mid-batch
        put(32'd50, 1'b0, 1'b0);
        put(32'd60, 1'b0, 1'b0);
        #3 rst = 1'b1;
        #1;
        chk("arst_in_ready",  64'(in_ready),  64'd0);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_data",  64'(out_data),  64'd0);
        chk("arst_out_count", 64'(out_count), 64'd0);
        chk("arst_out_ovf",   64'(out_ovf),   64'd0);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 4; i++) put(32'd1, 1'b0, 1'b0);
        chk("arst_batch_valid", 64'(out_valid), 64'd1);
        chk("arst_batch_data",  64'(out_data),  64'd4);
        chk("arst_batch_count", 64'(out_count), 64'd4);

        // Async reset while holding a result
        #3 rst = 1'b1;
        #1;
        chk("hrst_out_valid", 64'(out_valid), 64'd0);
        chk("hrst_out_data",  64'(out_data),  64'd0);
        @(negedge clk); rst = 1'b0;

        // Randomized stream against the arithmetic model
        m_a48 = 0; m_a33 = 0; m_o48 = 0; m_o33 = 0; m_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 7))
                0:       d = 32'h80000000;
                1:       d = 32'h7FFFFFFF;
                2:       d = 32'($urandom_range(0, 15));
                default: d = $urandom;
            endcase
            s = 1'($urandom_range(0, 1));
            l = ($urandom_range(0, 5) == 0);
            v = longint'($signed(d));
            if (s) v = -v;
            mstep(v, 48, m_a48, m_o48);
            mstep(v, 33, m_a33, m_o33);
            m_cnt++;
            put(d, s, l);
            if (l || m_cnt == 4) begin
                chk("rnd_valid",   64'(out_valid),   64'd1);
                chk("rnd_data",    64'(out_data),    64'(m_a48[47:0]));
                chk("rnd_count",   64'(out_count),   64'(m_cnt));
                chk("rnd_ovf",     64'(out_ovf),     64'(m_o48));
                chk("rnd_data33",  64'(out_data33),  64'(m_a33[32:0]));
                chk("rnd_ovf33",   64'(out_ovf33),   64'(m_o33));
                m_a48 = 0; m_a33 = 0; m_o48 = 0; m_o33 = 0; m_cnt = 0;
                consume($urandom_range(0, 3));
            end else begin
                chk("rnd_no_valid", 64'(out_valid), 64'd0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
